gcm_out_serializer: RTL and testbench

GCM_OUT_SERIALIZER -- requirements
Module: gcm_out_serializer

---
 rtl/gcm_out_serializer_if.sv | 10 +
 rtl/gcm_out_serializer.sv | 80 ++++++++
 tb/tb_gcm_out_serializer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/gcm_out_serializer_if.sv
// gcm_out_serializer_if: output beat stream from the GCM serializer to its consumer
interface gcm_out_serializer_if #(parameter int W = 32);
  logic         o_valid;
  logic         o_ready;
  logic [W-1:0] o_data;
  logic         o_is_tag;
  logic         o_last;
  modport master (output o_valid, o_data, o_is_tag, o_last, input o_ready);
  modport slave  (input o_valid, o_data, o_is_tag, o_last, output o_ready);
endinterface

// File: rtl/gcm_out_serializer.sv
// gcm_out_serializer: splits a 128-bit GCM cipher block and its tag into W-bit beats
module gcm_out_serializer #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_cp_ready,
  input  logic [0:127]   i_cipher_text,
  input  logic           i_tag_ready,
  input  logic [0:127]   i_tag,
  output logic           o_busy,
  output logic           o_overflow,
  gcm_out_serializer_if.master dout
);
  localparam int BEATS = 128 / W;
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  typedef enum logic [1:0] {IDLE, SEND_CT, WAIT_TAG, SEND_TAG} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [0:127]  ct_q, ct_d, tag_q, tag_d;
  logic          held_q, held_d, ovf_q, ovf_d, cp_r_q, tag_r_q;
  logic          cp_edge, tag_edge, fire, at_last, take_tag, take_cp;
  logic [6:0]    base;
  assign cp_edge       = i_cp_ready & ~cp_r_q;
  assign tag_edge      = i_tag_ready & ~tag_r_q;
  assign dout.o_valid  = state_q == SEND_CT || state_q == SEND_TAG;
  assign dout.o_is_tag = state_q == SEND_TAG;
  assign at_last       = cnt_q == LAST;
  assign dout.o_last   = dout.o_is_tag & at_last;
  assign fire          = dout.o_valid & dout.o_ready;
  assign o_busy        = state_q != IDLE;
  assign o_overflow    = ovf_q;
  assign base          = 7'(cnt_q) * 7'(W);
  assign dout.o_data   = !dout.o_valid ? '0 : dout.o_is_tag ? tag_q[base +: W] : ct_q[base +: W];
  // a new block may start in the same cycle the previous tag's final beat leaves
  assign take_cp  = cp_edge & (state_q == IDLE || (state_q == SEND_TAG && fire && at_last));
  assign take_tag = tag_edge & ~held_q &
                    (state_q == SEND_CT || state_q == WAIT_TAG || (state_q == IDLE && cp_edge));
  always_comb begin
    state_d = state_q;
    cnt_d   = fire ? (at_last ? '0 : cnt_q + 1'b1) : cnt_q;
    ct_d    = take_cp ? i_cipher_text : ct_q;
    tag_d   = take_tag ? i_tag : tag_q;
    held_d  = held_q | take_tag;
    ovf_d   = ovf_q | (cp_edge & ~take_cp) | (tag_edge & ~take_tag);
    if (take_cp) cnt_d = '0;
    case (state_q)
      IDLE:     state_d = take_cp ? SEND_CT : IDLE;
      SEND_CT:  state_d = fire && at_last ? (held_d ? SEND_TAG : WAIT_TAG) : SEND_CT;
      WAIT_TAG: state_d = take_tag ? SEND_TAG : WAIT_TAG;
      SEND_TAG: begin
        held_d  = fire && at_last ? 1'b0 : held_d;
        state_d = fire && at_last ? (take_cp ? SEND_CT : IDLE) : SEND_TAG;
      end
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ct_q    <= '0;
      tag_q   <= '0;
      held_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cp_r_q  <= 1'b0;
      tag_r_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ct_q    <= ct_d;
      tag_q   <= tag_d;
      held_q  <= held_d;
      ovf_q   <= ovf_d;
      cp_r_q  <= i_cp_ready;
      tag_r_q <= i_tag_ready;
    end
  end
endmodule

// File: tb/tb_gcm_out_serializer.sv
// tb_gcm_out_serializer: directed vectors for the W=32 and W=128 serializer
module tb_gcm_out_serializer;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  localparam logic [127:0] CT_A  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] CT_B  = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
  localparam logic [127:0] TAG_A = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
  logic cp, tg, cp2, tg2, busy, ovf, busy2, ovf2;
  logic [127:0] ct, tag, ct2, tag2;
  int n_chk = 0, n_err = 0, hs;
  gcm_out_serializer_if #(.W(32))  a();
  gcm_out_serializer_if #(.W(128)) b();
  gcm_out_serializer #(.W(32)) dut (
    .clk(clk), .rst(rst), .i_cp_ready(cp), .i_cipher_text(ct), .i_tag_ready(tg), .i_tag(tag),
    .o_busy(busy), .o_overflow(ovf), .dout(a.master));
  gcm_out_serializer #(.W(128)) dut_w128 (
    .clk(clk), .rst(rst), .i_cp_ready(cp2), .i_cipher_text(ct2), .i_tag_ready(tg2), .i_tag(tag2),
    .o_busy(busy2), .o_overflow(ovf2), .dout(b.master));
  task automatic check(input string t, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", t, got, exp);
    end
  endtask
  function automatic logic [31:0] word(input logic [127:0] v, input int k);
    return v[127 - 32 * k -: 32];
  endfunction
  task automatic beat(input string t, input logic [127:0] v, input int k, input logic is_tag);
    check({t, " valid"}, a.o_valid, 1'b1);
    check({t, " data"}, a.o_data, word(v, k));
    check({t, " is_tag"}, a.o_is_tag, is_tag);
    check({t, " last"}, a.o_last, is_tag && k == 3);
  endtask
  initial begin
    cp = 0; tg = 0; cp2 = 0; tg2 = 0;
    ct = CT_A; tag = TAG_A; ct2 = CT_A; tag2 = TAG_A;
    a.o_ready = 1; b.o_ready = 1;
    repeat (2) @(negedge clk);
    check("rst valid", a.o_valid, 0);
    check("rst data", a.o_data, 0);
    check("rst is_tag", a.o_is_tag, 0);
    check("rst last", a.o_last, 0);
    check("rst busy", busy, 0);
    check("rst ovf", ovf, 0);
    rst = 0;
    // back-to-back CT and tag
    cp = 1;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      beat("t1", k < 4 ? CT_A : TAG_A, k % 4, k >= 4);
      if (k == 1) tg = 1;
      @(negedge clk);
    end
    check("t1 idle valid", a.o_valid, 0);
    check("t1 idle busy", busy, 0);
    cp = 0; tg = 0;
    @(negedge clk);
    // late tag: WAIT_TAG for 20 cycles
    cp = 1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      beat("t2 ct", CT_A, k, 0);
      @(negedge clk);
    end
    for (int i = 0; i < 20; i++) begin
      check("t2 wait valid", a.o_valid, 0);
      check("t2 wait busy", busy, 1);
      @(negedge clk);
    end
    tg = 1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      beat("t2 tag", TAG_A, k, 1);
      @(negedge clk);
    end
    check("t2 ovf", ovf, 0);
    cp = 0; tg = 0;
    @(negedge clk);
    // ready pattern 1,0,0,1
    cp = 1; hs = 0;
    for (int c = 0; c < 60 && hs < 8; c++) begin
      a.o_ready = (c % 4 == 0) || (c % 4 == 3);
      if (c == 2) tg = 1;
      if (a.o_valid) beat("t3", hs < 4 ? CT_A : TAG_A, hs % 4, hs >= 4);
      if (a.o_valid && a.o_ready) hs++;
      @(negedge clk);
    end
    check("t3 handshakes", hs, 8);
    check("t3 end valid", a.o_valid, 0);
    a.o_ready = 1; cp = 0; tg = 0;
    @(negedge clk);
    // second cp edge during SEND_CT
    cp = 1; ct = CT_A;
    @(negedge clk);
    beat("t4 ct", CT_A, 0, 0);
    cp = 0;
    @(negedge clk);
    beat("t4 ct", CT_A, 1, 0);
    check("t4 ovf pre", ovf, 0);
    cp = 1; ct = CT_B; tg = 1;
    @(negedge clk);
    beat("t4 ct", CT_A, 2, 0);
    check("t4 ovf set", ovf, 1);
    @(negedge clk);
    beat("t4 ct", CT_A, 3, 0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      beat("t4 tag", TAG_A, k, 1);
      @(negedge clk);
    end
    check("t4 ovf sticky", ovf, 1);
    check("t4 end valid", a.o_valid, 0);
    cp = 0; tg = 0;
    @(negedge clk);
    // reset mid-stream
    cp = 1; ct = CT_A;
    @(negedge clk);
    beat("t5 ct", CT_A, 0, 0);
    @(negedge clk);
    beat("t5 ct", CT_A, 1, 0);
    @(negedge clk);
    cp = 0; rst = 1;
    #1;
    check("t5 rst valid", a.o_valid, 0);
    check("t5 rst data", a.o_data, 0);
    check("t5 rst is_tag", a.o_is_tag, 0);
    check("t5 rst last", a.o_last, 0);
    check("t5 rst busy", busy, 0);
    check("t5 rst ovf", ovf, 0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5 post valid", a.o_valid, 0);
      check("t5 post busy", busy, 0);
    end
    // cp held high across reset release
    rst = 1; cp = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    beat("t5 release", CT_A, 0, 0);
    rst = 1; cp = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    // W=128: cp and tag edges together
    cp2 = 1; tg2 = 1; ct2 = CT_B; tag2 = TAG_A;
    @(negedge clk);
    check("t6 ct valid", b.o_valid, 1);
    check("t6 ct data", b.o_data, CT_B);
    check("t6 ct is_tag", b.o_is_tag, 0);
    check("t6 ct last", b.o_last, 0);
    @(negedge clk);
    check("t6 tag valid", b.o_valid, 1);
    check("t6 tag data", b.o_data, TAG_A);
    check("t6 tag is_tag", b.o_is_tag, 1);
    check("t6 tag last", b.o_last, 1);
    @(negedge clk);
    check("t6 end valid", b.o_valid, 0);
    check("t6 end busy", busy2, 0);
    check("t6 ovf", ovf2, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
